// File: rtl/trail_writer.sv
// -----------------------------------------------------------------------------
// trail_writer
//   Write-side stage of the frame buffer. Each frame it paints the trail block
//   of every live bike into frameRAM as packed 16-bit words, and after reset or
//   on request it sweeps the whole buffer to the background colour.
//   Word format: pixel 2k in [3:0], pixel 2k+1 in [11:8].
//
// Ports
//   Clk            system clock (frame_clk is synchronous to it)
//   Reset          asynchronous active-high reset
//   frame_clk      frame strobe; a rising edge starts one frame's trail writes
//   clear_req      single-cycle request to clear the whole buffer
//   red_x/red_y    red bike pixel position
//   blue_x/blue_y  blue bike pixel position
//   red_alive      paint red trail this frame
//   blue_alive     paint blue trail this frame
//   write_address  frameRAM word address, (x>>1) + y*H_WORDS   (registered)
//   Data_Out       frameRAM write data                         (registered)
//   WE             frameRAM write enable                       (registered)
//   busy           high whenever the writer is not idle        (registered)
//   clear_done     one-cycle pulse alongside the last clear write
// -----------------------------------------------------------------------------
module trail_writer #(
    parameter int         H_WORDS    = 320,
    parameter int         V_LINES    = 480,
    parameter int         TRAIL_W    = 2,
    parameter logic [3:0] BG_COLOR   = 4'h8,
    parameter logic [3:0] RED_COLOR  = 4'h2,
    parameter logic [3:0] BLUE_COLOR = 4'h4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        clear_req,
    input  logic [9:0]  red_x,
    input  logic [9:0]  red_y,
    input  logic [9:0]  blue_x,
    input  logic [9:0]  blue_y,
    input  logic        red_alive,
    input  logic        blue_alive,
    output logic [18:0] write_address,
    output logic [15:0] Data_Out,
    output logic        WE,
    output logic        busy,
    output logic        clear_done
);

    localparam logic [17:0] CLR_LAST  = 18'(H_WORDS * V_LINES - 1);
    localparam logic [7:0]  ROW_LAST  = 8'(TRAIL_W - 1);
    localparam logic [7:0]  COL_LAST  = 8'(TRAIL_W / 2 - 1);
    localparam logic [10:0] PIX_LIMIT = 11'(2 * H_WORDS);
    localparam logic [10:0] ROW_LIMIT = 11'(V_LINES);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        IDLE    = 2'd1,
        WR_RED  = 2'd2,
        WR_BLUE = 2'd3
    } state_t;

    // Two pixels of the same colour packed into one frameRAM word.
    function automatic logic [15:0] pack_word(input logic [3:0] color);
        return {4'h0, color, 4'h0, color};
    endfunction

    // Row start address: row*320 as (row<<8)+(row<<6), widened to 19 bits first
    // so that no product bits are lost.
    function automatic logic [18:0] row_base(input logic [10:0] row);
        logic [18:0] row19;
        row19 = {8'h00, row};
        return (row19 << 8) + (row19 << 6);
    endfunction

    state_t      state_r, state_nx_s;
    logic [17:0] clr_cnt_r, clr_cnt_nx_s;
    logic [7:0]  row_r, row_nx_s;
    logic [7:0]  col_r, col_nx_s;
    logic        frame_clk_d_r;
    logic        edge_s;
    logic        latch_s;

    logic [9:0]  red_x_r, red_y_r, blue_x_r, blue_y_r;
    logic        blue_alive_r;

    logic [9:0]  bike_x_s, bike_y_s;
    logic [3:0]  bike_color_s;
    logic [10:0] pix_x_s;
    logic [10:0] row_s;
    logic [18:0] word_addr_s;
    logic        in_frame_s;
    logic        last_word_s;

    logic [18:0] addr_r, addr_nx_s;
    logic [15:0] data_r, data_nx_s;
    logic        we_r, we_nx_s;
    logic        busy_r, busy_nx_s;
    logic        done_r, done_nx_s;

    assign write_address = addr_r;
    assign Data_Out      = data_r;
    assign WE            = we_r;
    assign busy          = busy_r;
    assign clear_done    = done_r;

    assign edge_s = frame_clk & ~frame_clk_d_r;

    // Select the bike whose block is being painted.
    always_comb begin
        if (state_r == WR_BLUE) begin
            bike_x_s     = blue_x_r;
            bike_y_s     = blue_y_r;
            bike_color_s = BLUE_COLOR;
        end else begin
            bike_x_s     = red_x_r;
            bike_y_s     = red_y_r;
            bike_color_s = RED_COLOR;
        end
    end

    // Candidate word position inside the trail block; x is forced even so a
    // block always starts on a word boundary.
    always_comb begin
        pix_x_s     = {1'b0, bike_x_s & 10'h3FE} + {2'b00, col_r, 1'b0};
        row_s       = {1'b0, bike_y_s} + {3'b000, row_r};
        word_addr_s = row_base(row_s) + ({8'h00, pix_x_s} >> 1);
        in_frame_s  = (pix_x_s < PIX_LIMIT) && (row_s < ROW_LIMIT);
        last_word_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx_s   = state_r;
        clr_cnt_nx_s = clr_cnt_r;
        row_nx_s     = row_r;
        col_nx_s     = col_r;
        latch_s      = 1'b0;
        we_nx_s      = 1'b0;
        addr_nx_s    = 19'd0;
        data_nx_s    = 16'h0000;
        done_nx_s    = 1'b0;

        if (clear_req) begin
            // Clear overrides everything: write address 0 right away and
            // abandon any trail block in progress.
            state_nx_s   = CLEAR;
            clr_cnt_nx_s = 18'd1;
            row_nx_s     = 8'd0;
            col_nx_s     = 8'd0;
            we_nx_s      = 1'b1;
            addr_nx_s    = 19'd0;
            data_nx_s    = pack_word(BG_COLOR);
        end else begin
            case (state_r)
                CLEAR: begin
                    we_nx_s   = 1'b1;
                    addr_nx_s = {1'b0, clr_cnt_r};
                    data_nx_s = pack_word(BG_COLOR);
                    if (clr_cnt_r == CLR_LAST) begin
                        done_nx_s    = 1'b1;
                        clr_cnt_nx_s = 18'd0;
                        state_nx_s   = IDLE;
                    end else begin
                        clr_cnt_nx_s = clr_cnt_r + 18'd1;
                    end
                end
                IDLE: begin
                    if (edge_s) begin
                        latch_s  = 1'b1;
                        row_nx_s = 8'd0;
                        col_nx_s = 8'd0;
                        if (red_alive) begin
                            state_nx_s = WR_RED;
                        end else if (blue_alive) begin
                            state_nx_s = WR_BLUE;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                WR_RED, WR_BLUE: begin
                    // Clipped words still use their cycle, just without WE.
                    we_nx_s   = in_frame_s;
                    addr_nx_s = word_addr_s;
                    data_nx_s = pack_word(bike_color_s);
                    if (last_word_s) begin
                        row_nx_s = 8'd0;
                        col_nx_s = 8'd0;
                        if ((state_r == WR_RED) && blue_alive_r) begin
                            state_nx_s = WR_BLUE;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else if (col_r == COL_LAST) begin
                        col_nx_s = 8'd0;
                        row_nx_s = row_r + 8'd1;
                    end else begin
                        col_nx_s = col_r + 8'd1;
                    end
                end
                default: begin
                    state_nx_s   = CLEAR;
                    clr_cnt_nx_s = 18'd0;
                    row_nx_s     = 8'd0;
                    col_nx_s     = 8'd0;
                end
            endcase
        end

        // busy covers both the cycle a non-idle state is entered and the
        // cycle carrying that state's final output word.
        busy_nx_s = (state_nx_s != IDLE) || (state_r != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r       <= CLEAR;
            clr_cnt_r     <= 18'd0;
            row_r         <= 8'd0;
            col_r         <= 8'd0;
            frame_clk_d_r <= 1'b0;
            addr_r        <= 19'd0;
            data_r        <= 16'h0000;
            we_r          <= 1'b0;
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            clr_cnt_r     <= clr_cnt_nx_s;
            row_r         <= row_nx_s;
            col_r         <= col_nx_s;
            frame_clk_d_r <= frame_clk;
            addr_r        <= addr_nx_s;
            data_r        <= data_nx_s;
            we_r          <= we_nx_s;
            busy_r        <= busy_nx_s;
            done_r        <= done_nx_s;
        end
    end

    // Bike positions captured at the frame edge so they hold steady while the
    // blocks are painted.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            red_x_r      <= 10'd0;
            red_y_r      <= 10'd0;
            blue_x_r     <= 10'd0;
            blue_y_r     <= 10'd0;
            blue_alive_r <= 1'b0;
        end else if (latch_s) begin
            red_x_r      <= red_x;
            red_y_r      <= red_y;
            blue_x_r     <= blue_x;
            blue_y_r     <= blue_y;
            blue_alive_r <= blue_alive;
        end else begin
            red_x_r      <= red_x_r;
            red_y_r      <= red_y_r;
            blue_x_r     <= blue_x_r;
            blue_y_r     <= blue_y_r;
            blue_alive_r <= blue_alive_r;
        end
    end

endmodule

// File: tb/tb_trail_writer.sv
// -----------------------------------------------------------------------------
// tb_trail_writer
//   Directed bench for trail_writer. The frame height is shortened to 52 lines
//   so that each clear sweep is 16640 words; the row address arithmetic
//   (y*320) is independent of the line count, so addresses below match the
//   full-size frame.
// -----------------------------------------------------------------------------
module tb_trail_writer;

    localparam int V_LINES_TB = 52;
    localparam int LAST       = 320 * V_LINES_TB - 1;   // 16639

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic        clear_req;
    logic [9:0]  red_x, red_y, blue_x, blue_y;
    logic        red_alive, blue_alive;
    logic [18:0] write_address;
    logic [15:0] Data_Out;
    logic        WE, busy, clear_done;

    int checks   = 0;
    int failures = 0;

    trail_writer #(.V_LINES(V_LINES_TB)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .clear_req     (clear_req),
        .red_x         (red_x),
        .red_y         (red_y),
        .blue_x        (blue_x),
        .blue_y        (blue_y),
        .red_alive     (red_alive),
        .blue_alive    (blue_alive),
        .write_address (write_address),
        .Data_Out      (Data_Out),
        .WE            (WE),
        .busy          (busy),
        .clear_done    (clear_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_wr(input string tag, input logic [18:0] a, input logic [15:0] d);
        check({tag, "_we"},   32'(WE), 32'd1);
        check({tag, "_addr"}, 32'(write_address), 32'(a));
        check({tag, "_data"}, 32'(Data_Out), 32'(d));
    endtask

    task automatic exp_quiet(input string tag, input logic b);
        check({tag, "_we"},   32'(WE), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    // Follow a clear sweep from address 'first' to the end; optionally raise a
    // frame edge after address 'edge_at' has been written.
    task automatic run_sweep(input string tag, input int first, input int edge_at);
        int bad;
        bad = 0;
        for (int i = first; i <= LAST; i++) begin
            tick();
            if (WE !== 1'b1 || write_address !== 19'(i) || Data_Out !== 16'h0808 ||
                clear_done !== (i == LAST) || busy !== 1'b1) begin
                bad++;
            end
            if (i == edge_at) frame_clk = 1'b1;
            if (i == edge_at + 2) frame_clk = 1'b0;
        end
        check({tag, "_bad"},  32'(bad), 32'd0);
        check({tag, "_done"}, 32'(clear_done), 32'd1);
        check({tag, "_last"}, 32'(write_address), 32'(LAST));
        tick();
        exp_quiet({tag, "_end"}, 1'b0);
        check({tag, "_donefall"}, 32'(clear_done), 32'd0);
    endtask

    initial begin
        Reset      = 1'b0;
        frame_clk  = 1'b0;
        clear_req  = 1'b0;
        red_x      = 10'd0;
        red_y      = 10'd0;
        blue_x     = 10'd0;
        blue_y     = 10'd0;
        red_alive  = 1'b0;
        blue_alive = 1'b0;

        // Reset state
        #2 Reset = 1'b1;
        #1;
        check("rst_we",   32'(WE), 32'd0);
        check("rst_addr", 32'(write_address), 32'd0);
        check("rst_data", 32'(Data_Out), 32'd0);
        check("rst_done", 32'(clear_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        tick();
        tick();
        Reset = 1'b0;

        // Sweep after reset release: first write on the first edge
        run_sweep("sw1", 0, -1);

        // Red only at (100,50)
        red_x = 10'd100; red_y = 10'd50; red_alive = 1'b1; blue_alive = 1'b0;
        frame_clk = 1'b1;
        tick();
        exp_quiet("t2_lat", 1'b1);
        tick();
        exp_wr("t2_w0", 19'd16050, 16'h0202);
        tick();
        exp_wr("t2_w1", 19'd16370, 16'h0202);
        tick();
        exp_quiet("t2_end", 1'b0);
        frame_clk = 1'b0;
        tick();

        // Edge with both bikes dead: stays idle
        red_alive = 1'b0; blue_alive = 1'b0;
        frame_clk = 1'b1;
        tick();
        exp_quiet("t_none", 1'b0);
        frame_clk = 1'b0;
        tick();

        // Red at (101,50) then blue at (0,0); a second edge mid-block is ignored
        red_x = 10'd101; red_y = 10'd50; blue_x = 10'd0; blue_y = 10'd0;
        red_alive = 1'b1; blue_alive = 1'b1;
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
        exp_wr("t3_r0", 19'd16050, 16'h0202);
        frame_clk = 1'b1;
        tick();
        exp_wr("t3_r1", 19'd16370, 16'h0202);
        tick();
        exp_wr("t3_b0", 19'd0, 16'h0404);
        tick();
        exp_wr("t3_b1", 19'd320, 16'h0404);
        tick();
        exp_quiet("t3_end", 1'b0);
        frame_clk = 1'b0;
        tick();
        exp_quiet("t3_drop", 1'b0);

        // Blue at the bottom-right corner: second row falls off the frame
        blue_x = 10'd639; blue_y = 10'd51; red_alive = 1'b0; blue_alive = 1'b1;
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
        exp_wr("t4_b0", 19'd16639, 16'h0404);
        tick();
        exp_quiet("t4_clip", 1'b1);
        tick();
        exp_quiet("t4_end", 1'b0);

        // Clear request and frame edge together in idle: clear wins
        blue_x = 10'd0; blue_y = 10'd0;
        frame_clk = 1'b1;
        clear_req = 1'b1;
        tick();
        exp_wr("t_same_c0", 19'd0, 16'h0808);
        clear_req = 1'b0;
        frame_clk = 1'b0;
        tick();
        exp_wr("t_same_c1", 19'd1, 16'h0808);
        tick();
        exp_wr("t_same_c2", 19'd2, 16'h0808);
        // Clear request during the sweep restarts it
        clear_req = 1'b1;
        tick();
        exp_wr("t_restart", 19'd0, 16'h0808);
        clear_req = 1'b0;
        run_sweep("sw2", 1, -1);

        // Clear request right after red's first write abandons the block
        red_x = 10'd100; red_y = 10'd50; red_alive = 1'b1; blue_alive = 1'b0;
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
        exp_wr("t5_r0", 19'd16050, 16'h0202);
        clear_req = 1'b1;
        tick();
        exp_wr("t5_c0", 19'd0, 16'h0808);
        clear_req = 1'b0;
        // Frame edge at clear address 1000 is dropped
        run_sweep("sw3", 1, 1000);
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_quiet("t6_quiet", 1'b0);
        end

        // Reset pulse in the middle of the blue block
        blue_x = 10'd0; blue_y = 10'd0; red_alive = 1'b0; blue_alive = 1'b1;
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
        exp_wr("t6_b0", 19'd0, 16'h0404);
        #1 Reset = 1'b1;
        #1;
        check("t6_rst_we",   32'(WE), 32'd0);
        check("t6_rst_addr", 32'(write_address), 32'd0);
        check("t6_rst_data", 32'(Data_Out), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd1);
        tick();
        check("t6_rst_hold", 32'(WE), 32'd0);
        Reset = 1'b0;
        tick();
        exp_wr("t6_c0", 19'd0, 16'h0808);
        tick();
        exp_wr("t6_c1", 19'd1, 16'h0808);
        tick();
        exp_wr("t6_c2", 19'd2, 16'h0808);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
